mips_mc_ctrl: RTL

- Multi-cycle control FSM for the MIPS datapath; sequences the shared ALU, register file, PC and unified memory.
- Decodes OPCODE and steps each instruction through fetch, decode, execute, memory and writeback.
- Drives ALU input select, ALU op class, register/PC write enables and the memory request handshake.
- Consumes SIG_B, the ALU branch-taken flag, for BEQ.

---
 rtl/mips_mc_ctrl_pkg.sv | 48 ++++
 rtl/mips_mc_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM state
// codes and the select/op encodings seen by the ALU control and datapath muxes.
package mips_mc_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] RTYPE_OP = 6'b000000;
    localparam logic [5:0] LW_OP    = 6'b100011;
    localparam logic [5:0] SW_OP    = 6'b101011;
    localparam logic [5:0] BEQ_OP   = 6'b000100;
    localparam logic [5:0] ADDI_OP  = 6'b001000;
    localparam logic [5:0] J_OP     = 6'b000010;

    // FSM state encoding (4-bit, 11 states). Writeback is split by source
    // instruction so REG_DST is a pure function of state.
    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_EXEC_R = 4'd2;
    localparam logic [3:0] ST_EXEC_I = 4'd3;
    localparam logic [3:0] ST_WB_R   = 4'd4;
    localparam logic [3:0] ST_WB_I   = 4'd5;
    localparam logic [3:0] ST_MEM_RD = 4'd6;
    localparam logic [3:0] ST_MEM_WB = 4'd7;
    localparam logic [3:0] ST_MEM_WR = 4'd8;
    localparam logic [3:0] ST_BRANCH = 4'd9;
    localparam logic [3:0] ST_JUMP   = 4'd10;

    // ALU op class
    localparam logic [1:0] ALU_OP_ADD  = 2'd0;
    localparam logic [1:0] ALU_OP_SUB  = 2'd1;
    localparam logic [1:0] ALU_OP_FUNC = 2'd2;

    // ALU B-input select
    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Opcodes that go through the immediate execute step
    function automatic logic is_itype(input logic [5:0] op);
        return (op == LW_OP) || (op == SW_OP) || (op == ADDI_OP);
    endfunction

endpackage

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM. Sequences fetch/decode/execute/memory/
// writeback and drives the datapath selects, write enables and memory request.
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | instruction read from PC, PC+4 on accept
// DECODE    | opcode decode, branch target precomputed
// EXEC_R    | R-type ALU operation (FUNC)
// EXEC_I    | base + sign-ext immediate (LW/SW/ADDI)
// WB_R      | R-type result to rd
// WB_I      | ADDI result to rt
// MEM_RD    | data read at ALUOut, waits for MEM_READY
// MEM_WB    | loaded MDR to rt
// MEM_WR    | data write at ALUOut, waits for MEM_READY
// BRANCH    | compare rs/rt, PC <- target if taken
// JUMP      | PC <- jump target
module mips_mc_ctrl
    import mips_mc_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_opcode,
    input  logic       i_sig_b,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_i_or_d,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic [1:0] o_pc_src,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_reg_write,
    output logic       o_illegal,
    output logic       o_busy_fetch
);

    logic [3:0] r_state;
    logic [3:0] w_next;

    // State register; reset returns to FETCH immediately
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_FETCH;
        else       r_state <= w_next;
    end

    // Next-state and output decode; outputs are forced quiet while in reset
    // so an in-flight memory request drops without waiting for a clock
    always_comb begin
        w_next       = r_state;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_i_or_d     = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_pc_src     = PCSRC_ALU;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = SRCB_RT;
        o_alu_op     = ALU_OP_ADD;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_reg_write  = 1'b0;
        o_illegal    = 1'b0;
        o_busy_fetch = 1'b0;
        if (i_rst) begin
            w_next       = ST_FETCH;
            o_busy_fetch = 1'b1;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    o_busy_fetch = 1'b1;
                    o_mem_req    = 1'b1;
                    o_alu_src_b  = SRCB_FOUR;
                    if (i_mem_ready) begin
                        o_ir_write = 1'b1;
                        o_pc_write = 1'b1;
                        w_next     = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    o_alu_src_b = SRCB_IMM_SH;
                    if (i_opcode == RTYPE_OP)      w_next = ST_EXEC_R;
                    else if (is_itype(i_opcode))   w_next = ST_EXEC_I;
                    else if (i_opcode == BEQ_OP)   w_next = ST_BRANCH;
                    else if (i_opcode == J_OP)     w_next = ST_JUMP;
                    else begin
                        o_illegal = 1'b1;
                        w_next    = ST_FETCH;
                    end
                end
                ST_EXEC_R: begin
                    o_alu_src_a = 1'b1;
                    o_alu_op    = ALU_OP_FUNC;
                    w_next      = ST_WB_R;
                end
                ST_EXEC_I: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = SRCB_IMM;
                    case (i_opcode)
                        LW_OP:   w_next = ST_MEM_RD;
                        SW_OP:   w_next = ST_MEM_WR;
                        ADDI_OP: w_next = ST_WB_I;
                        default: w_next = ST_FETCH;
                    endcase
                end
                ST_WB_R: begin
                    o_reg_write = 1'b1;
                    o_reg_dst   = 1'b1;
                    w_next      = ST_FETCH;
                end
                ST_WB_I: begin
                    o_reg_write = 1'b1;
                    w_next      = ST_FETCH;
                end
                ST_MEM_RD: begin
                    o_mem_req = 1'b1;
                    o_i_or_d  = 1'b1;
                    if (i_mem_ready) w_next = ST_MEM_WB;
                end
                ST_MEM_WB: begin
                    o_reg_write  = 1'b1;
                    o_mem_to_reg = 1'b1;
                    w_next       = ST_FETCH;
                end
                ST_MEM_WR: begin
                    o_mem_req = 1'b1;
                    o_mem_we  = 1'b1;
                    o_i_or_d  = 1'b1;
                    if (i_mem_ready) w_next = ST_FETCH;
                end
                ST_BRANCH: begin
                    o_alu_src_a = 1'b1;
                    o_alu_op    = ALU_OP_SUB;
                    o_pc_src    = PCSRC_ALUOUT;
                    o_pc_write  = i_sig_b;
                    w_next      = ST_FETCH;
                end
                ST_JUMP: begin
                    o_pc_write = 1'b1;
                    o_pc_src   = PCSRC_JUMP;
                    w_next     = ST_FETCH;
                end
                default: w_next = ST_FETCH;
            endcase
        end
    end

endmodule
